// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the processor datapath. Each instruction
//   walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block owns the
//   memory request/ready handshake and faults if memory hangs.
//
// Parameters
//   MEM_TIMEOUT   max FETCH/MEM wait cycles before FAULT (1..255)
//   CNT_W         retired-instruction counter width (SEQ_INSTR_CNT_EN only)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   run                 level enable, checked only at instruction boundaries
//   opcode, aluop       instruction register fields, sampled in DECODE
//   zero_flag           ALU zero result, sampled in EXEC for branches
//   mem_ready           memory completes the current request
//   mem_req/sel/we      memory request, 0=fetch/1=data select, store enable
//   ir_load             load instruction register (same cycle as mem_ready)
//   pc_en, branch       advance PC once per instruction, take branch target
//   opb_select          1 = immediate operand B
//   reg_write           register-file write enable
//   data_from_mem       write-back source is memory
//   alu_signal          ALU function
//   busy/halted/fault   status: sequencing, HALT state, sticky fault
//   instr_count         retired-instruction count (SEQ_INSTR_CNT_EN only)
//
// Optional feature: define SEQ_INSTR_CNT_EN to add instr_count.

module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
`ifdef SEQ_INSTR_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic [2:0] aluop,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_en,
  output logic       branch,
  output logic       opb_select,
  output logic       reg_write,
  output logic       data_from_mem,
  output logic [2:0] alu_signal,
  output logic       busy,
  output logic       halted,
`ifdef SEQ_INSTR_CNT_EN
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_ALUI  = 5'd1;
  localparam logic [4:0] OP_LOAD  = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_BEQZ  = 5'd4;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [2:0] aluop_q, aluop_d;
  logic [7:0] tmo_q, tmo_d;
  logic       fault_q, fault_d;
  logic [7:0] tmo_inc;
  state_e     after_instr;

  assign tmo_inc     = tmo_q + 8'd1;
  // run is only consulted when an instruction retires.
  assign after_instr = run ? S_FETCH : S_IDLE;

  // Outputs are decoded from the registered state; only ir_load and the
  // store-completion pc_en also look at mem_ready so they land in the
  // cycle the handshake completes.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    aluop_d       = aluop_q;
    tmo_d         = 8'd0;
    fault_d       = fault_q;
    mem_req       = 1'b0;
    mem_sel       = 1'b0;
    mem_we        = 1'b0;
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    branch        = 1'b0;
    opb_select    = 1'b0;
    reg_write     = 1'b0;
    data_from_mem = 1'b0;
    alu_signal    = 3'd0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_inc == TIMEOUT_C) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      S_DECODE: begin
        op_d    = opcode;
        aluop_d = aluop;
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode > OP_BEQZ) begin
          // Illegal opcode: retire it as a no-op but remember the fault.
          pc_en   = 1'b1;
          fault_d = 1'b1;
          state_d = after_instr;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_RTYPE: begin
            alu_signal = aluop_q;
            state_d    = S_WB;
          end
          OP_ALUI: begin
            opb_select = 1'b1;
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            opb_select = 1'b1;
            state_d    = S_MEM;
          end
          OP_BEQZ: begin
            alu_signal = 3'd1;
            pc_en      = 1'b1;
            branch     = zero_flag;
            state_d    = after_instr;
          end
          default: state_d = after_instr;
        endcase
      end

      S_MEM: begin
        mem_req    = 1'b1;
        mem_sel    = 1'b1;
        mem_we     = (op_q == OP_STORE);
        // Keep base + immediate on the ALU so the address is stable for
        // the whole handshake.
        opb_select = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_en   = 1'b1;
            state_d = after_instr;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_inc == TIMEOUT_C) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      S_WB: begin
        reg_write     = 1'b1;
        data_from_mem = (op_q == OP_LOAD);
        pc_en         = 1'b1;
        state_d       = after_instr;
      end

      default: ; // HALT and FAULT only leave through rst
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
  assign halted = (state_q == S_HALT);
  assign fault  = fault_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of the others.
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 5'd0;
      aluop_q <= 3'd0;
      tmo_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      aluop_q <= aluop_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

`ifdef SEQ_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wraps naturally from all-ones to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Self-checking bench for multicycle_sequencer: a table of per-cycle
//   {inputs, expected outputs} records built from short hand-written
//   instruction sequences, with expected values routed through a queue.

module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, zero_flag, mem_ready;
  logic [4:0] opcode;
  logic [2:0] aluop;
  logic       mem_req, mem_sel, mem_we, ir_load, pc_en, branch;
  logic       opb_select, reg_write, data_from_mem, busy, halted, fault;
  logic [2:0] alu_signal;
`ifdef SEQ_INSTR_CNT_EN
  logic [3:0] instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .MEM_TIMEOUT(15)
`ifdef SEQ_INSTR_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .aluop(aluop),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load),
    .pc_en(pc_en), .branch(branch), .opb_select(opb_select),
    .reg_write(reg_write), .data_from_mem(data_from_mem),
    .alu_signal(alu_signal), .busy(busy), .halted(halted),
`ifdef SEQ_INSTR_CNT_EN
    .instr_count(instr_count),
`endif
    .fault(fault)
  );

  typedef struct packed {
    logic       rst;
    logic       run;
    logic [4:0] opcode;
    logic [2:0] aluop;
    logic       zero_flag;
    logic       mem_ready;
  } in_t;

  typedef struct packed {
    logic       mem_req, mem_sel, mem_we, ir_load, pc_en, branch;
    logic       opb_select, reg_write, data_from_mem;
    logic [2:0] alu_signal;
    logic       busy, halted, fault;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  out_t act;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign act = {mem_req, mem_sel, mem_we, ir_load, pc_en, branch, opb_select,
                reg_write, data_from_mem, alu_signal, busy, halted, fault};

  task automatic check(input string nm, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic in_t mk(logic r, logic rn, logic [4:0] op, logic [2:0] a,
                             logic zf, logic rdy);
    in_t v;
    v = '{rst: r, run: rn, opcode: op, aluop: a, zero_flag: zf, mem_ready: rdy};
    return v;
  endfunction

  // Expected-output builders, one per control state of the sequencer.
  function automatic out_t f_idle(logic flt);
    out_t r = '0; r.fault = flt; return r;
  endfunction
  function automatic out_t f_fetch(logic rdy, logic flt);
    out_t r = '0; r.mem_req = 1; r.ir_load = rdy; r.busy = 1; r.fault = flt; return r;
  endfunction
  function automatic out_t f_dec(logic ill, logic flt);
    out_t r = '0; r.pc_en = ill; r.busy = 1; r.fault = flt; return r;
  endfunction
  function automatic out_t f_exr(logic [2:0] a, logic flt);
    out_t r = '0; r.alu_signal = a; r.busy = 1; r.fault = flt; return r;
  endfunction
  function automatic out_t f_exim(logic flt);
    out_t r = '0; r.opb_select = 1; r.busy = 1; r.fault = flt; return r;
  endfunction
  function automatic out_t f_exb(logic zf, logic flt);
    out_t r = '0; r.alu_signal = 3'd1; r.pc_en = 1; r.branch = zf; r.busy = 1;
    r.fault = flt; return r;
  endfunction
  function automatic out_t f_mem(logic we, logic rdy, logic flt);
    out_t r = '0; r.mem_req = 1; r.mem_sel = 1; r.mem_we = we; r.opb_select = 1;
    r.pc_en = we & rdy; r.busy = 1; r.fault = flt; return r;
  endfunction
  function automatic out_t f_wb(logic ld, logic flt);
    out_t r = '0; r.reg_write = 1; r.data_from_mem = ld; r.pc_en = 1; r.busy = 1;
    r.fault = flt; return r;
  endfunction
  function automatic out_t f_halt();
    out_t r = '0; r.halted = 1; return r;
  endfunction
  function automatic out_t f_fault();
    out_t r = '0; r.fault = 1; return r;
  endfunction

  task automatic add(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.name = nm; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst = i.rst; run = i.run; opcode = i.opcode; aluop = i.aluop;
    zero_flag = i.zero_flag; mem_ready = i.mem_ready;
  endtask

  initial begin
    // ---------------- vector table ----------------
    add("reset_idle",   mk(0,0,0,0,0,0), f_idle(0));
    // R-type, aluop 3
    add("r_idle",       mk(0,1,0,3,0,1), f_idle(0));
    add("r_fetch",      mk(0,1,0,3,0,1), f_fetch(1,0));
    add("r_decode",     mk(0,1,0,3,0,1), f_dec(0,0));
    add("r_exec",       mk(0,1,0,3,0,1), f_exr(3'd3,0));
    add("r_wb",         mk(0,1,0,3,0,1), f_wb(0,0));
    // ALU immediate (aluop ignored)
    add("i_fetch",      mk(0,1,1,5,0,1), f_fetch(1,0));
    add("i_decode",     mk(0,1,1,5,0,1), f_dec(0,0));
    add("i_exec",       mk(0,1,1,5,0,1), f_exim(0));
    add("i_wb",         mk(0,1,1,5,0,1), f_wb(0,0));
    // load with 3-cycle memory wait
    add("ld_fetch",     mk(0,1,2,0,0,1), f_fetch(1,0));
    add("ld_decode",    mk(0,1,2,0,0,1), f_dec(0,0));
    add("ld_exec",      mk(0,1,2,0,0,0), f_exim(0));
    for (int k = 0; k < 3; k++)
      add("ld_mem_wait", mk(0,1,2,0,0,0), f_mem(0,0,0));
    add("ld_mem_done",  mk(0,1,2,0,0,1), f_mem(0,1,0));
    add("ld_wb",        mk(0,1,2,0,0,1), f_wb(1,0));
    // branch taken / not taken, run dropped on the second
    add("bz_fetch",     mk(0,1,4,0,1,1), f_fetch(1,0));
    add("bz_decode",    mk(0,1,4,0,1,1), f_dec(0,0));
    add("bz_exec_t",    mk(0,1,4,0,1,1), f_exb(1,0));
    add("bnz_fetch",    mk(0,1,4,0,0,1), f_fetch(1,0));
    add("bnz_decode",   mk(0,1,4,0,0,1), f_dec(0,0));
    add("bnz_exec_nt",  mk(0,0,4,0,0,1), f_exb(0,0));
    add("bnz_to_idle",  mk(0,0,0,0,0,1), f_idle(0));
    // store, run dropped mid-instruction: completes, then IDLE
    add("st_idle",      mk(0,1,3,0,0,1), f_idle(0));
    add("st_fetch",     mk(0,1,3,0,0,1), f_fetch(1,0));
    add("st_decode",    mk(0,0,3,0,0,1), f_dec(0,0));
    add("st_exec",      mk(0,0,3,0,0,0), f_exim(0));
    add("st_mem_wait",  mk(0,0,3,0,0,0), f_mem(1,0,0));
    add("st_mem_done",  mk(0,0,3,0,0,1), f_mem(1,1,0));
    add("st_to_idle",   mk(0,0,0,0,0,1), f_idle(0));
    // illegal opcode: pc_en pulse, sticky fault, execution continues
    add("ill_idle",     mk(0,1,7,0,0,1), f_idle(0));
    add("ill_fetch",    mk(0,1,7,0,0,1), f_fetch(1,0));
    add("ill_decode",   mk(0,1,7,0,0,1), f_dec(1,0));
    add("ill_next_fetch", mk(0,1,0,0,0,1), f_fetch(1,1));
    add("ill_sticky",   mk(0,1,0,0,0,1), f_dec(0,1));
    add("ill_rst_exec", mk(1,1,0,0,0,1), f_exr(3'd0,1));
    add("fault_cleared", mk(0,0,0,0,0,0), f_idle(0));
    // halt
    add("h_idle",       mk(0,1,31,0,0,1), f_idle(0));
    add("h_fetch",      mk(0,1,31,0,0,1), f_fetch(1,0));
    add("h_decode",     mk(0,1,31,0,0,1), f_dec(0,0));
    add("h_halt",       mk(0,1,0,0,0,1), f_halt());
    add("h_halt_hold",  mk(0,1,0,0,0,1), f_halt());
    add("h_rst",        mk(1,1,0,0,0,1), f_halt());
    // reset in the middle of a store handshake
    add("rs_idle",      mk(0,1,3,0,0,1), f_idle(0));
    add("rs_fetch",     mk(0,1,3,0,0,1), f_fetch(1,0));
    add("rs_decode",    mk(0,1,3,0,0,0), f_dec(0,0));
    add("rs_exec",      mk(0,1,3,0,0,0), f_exim(0));
    add("rs_mem_rst",   mk(1,1,3,0,0,0), f_mem(1,0,0));
    add("rs_idle_after", mk(0,0,0,0,0,0), f_idle(0));
    // timeout boundary: ready on the 15th FETCH cycle is still in time
    add("tb_idle",      mk(0,1,0,6,0,0), f_idle(0));
    for (int k = 0; k < 14; k++)
      add("tb_fetch_wait", mk(0,1,0,6,0,0), f_fetch(0,0));
    add("tb_fetch_last", mk(0,1,0,6,0,1), f_fetch(1,0));
    add("tb_decode",    mk(0,0,0,6,0,1), f_dec(0,0));
    add("tb_exec",      mk(0,0,0,0,0,1), f_exr(3'd6,0));
    add("tb_wb",        mk(0,0,0,0,0,1), f_wb(0,0));
    // timeout: 15 waiting FETCH cycles, then FAULT
    add("to_idle",      mk(0,1,0,0,0,0), f_idle(0));
    for (int k = 0; k < 15; k++)
      add("to_fetch_wait", mk(0,1,0,0,0,0), f_fetch(0,0));
    add("to_fault",     mk(0,1,0,0,0,1), f_fault());
    add("to_fault_hold", mk(0,1,0,0,0,1), f_fault());
    add("to_rst",       mk(1,1,0,0,0,1), f_fault());
    add("to_cleared",   mk(0,0,0,0,0,0), f_idle(0));

    // ---------------- apply ----------------
    drive(mk(1,0,0,0,0,0));
    repeat (2) @(posedge clk);
    foreach (vecs[n]) begin
      #1;
      drive(vecs[n].i);
      sb.push_back(vecs[n].o);
      @(negedge clk);
      check(vecs[n].name, act, sb.pop_front());
      @(posedge clk);
    end

`ifdef SEQ_INSTR_CNT_EN
    begin
      int pulses = 0;
      int cyc    = 0;
      #1;
      drive(mk(1,0,0,0,0,0));
      @(posedge clk);
      #1;
      check_val("cnt_reset", int'(instr_count), 0);
      drive(mk(0,1,0,1,0,1));
      while (pulses < 17 && cyc < 500) begin
        @(negedge clk);
        if (pc_en) pulses++;
        cyc++;
      end
      check_val("cnt_pulses", pulses, 17);
      @(posedge clk);
      #1;
      check_val("cnt_wrap", int'(instr_count), 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the processor datapath: FETCH, DECODE, EXEC, MEM, WB.
- Drives the register file, ALU, memory port and PC from the 5-bit opcode and 3-bit ALU op held in the instruction register.
- Replaces the single-cycle control path.
- Owns the memory request/ready handshake and detects a hung memory with a timeout.

Parameters:
- MEM_TIMEOUT, 15: max cycles mem_req may wait for mem_ready before a fault (range 1..255).
- CNT_W, 16: width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; enables instruction sequencing.
- opcode  in  5  instruction-register opcode; sampled in DECODE.
- aluop  in  3  instruction-register ALU op; sampled in DECODE.
- zero_flag  in  1  ALU zero result; sampled in EXEC for branches.
- mem_ready  in  1  memory completes the current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_sel  out  1  0 = instruction fetch, 1 = data access.
- mem_we  out  1  data write (store).
- ir_load  out  1  load instruction register.
- pc_en  out  1  advance PC (one-cycle pulse per instruction).
- branch  out  1  take branch target on this pc_en.
- opb_select  out  1  1 = immediate operand B.
- reg_write  out  1  register-file write enable.
- data_from_mem  out  1  write-back source is memory.
- alu_signal  out  3  ALU function.
- busy  out  1  not IDLE, HALT or FAULT.
- halted  out  1  HALT state.
- fault  out  1  sticky fault (illegal opcode or timeout).

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-handshake): state=IDLE, latched opcode/aluop=0, timeout counter=0, fault=0. All outputs 0 in IDLE.
- Opcodes: 0 ALU R-type, 1 ALU immediate, 2 load, 3 store, 4 branch-if-zero, 31 halt; all other values are illegal.
- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, mem_sel=0.
  - mem_ready=1: ir_load=1 (combinational, same cycle), go to DECODE.
- DECODE (1 cycle): latch opcode/aluop.
  - 31 -> HALT.
  - Illegal -> pc_en=1, fault set, then FETCH if run=1, else IDLE.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - alu_signal = latched aluop for op 0; 3'd0 (add) for ops 1/2/3; 3'd1 (sub) for op 4.
  - opb_select=1 for ops 1/2/3.
  - Ops 0/1 -> WB. Ops 2/3 -> MEM.
  - Op 4: pc_en=1, branch=zero_flag, then FETCH/IDLE.
- MEM: mem_req=1, mem_sel=1, mem_we=1 only for op 3. alu_signal held at 3'd0 so the address stays stable.
  - On mem_ready: load -> WB; store -> pc_en=1, then FETCH/IDLE.
- WB (1 cycle): reg_write=1, data_from_mem=(op==2), pc_en=1, then FETCH/IDLE.
- Instruction boundary: run is checked only at the end of an instruction. Deasserting run mid-instruction completes that instruction and then goes to IDLE.
- Timeout:
  - Counter increments each FETCH/MEM cycle with mem_ready=0.
  - Clears on mem_ready or on leaving the state.
  - Reaching MEM_TIMEOUT: enter FAULT, deassert mem_req, set fault.
- FAULT and HALT: all outputs 0 except fault or halted respectively. Exit only via rst.
- fault is sticky until rst; an illegal opcode sets it but execution continues.
- Output latency: pc_en, reg_write and mem_we are never asserted together with mem_req=0 except in WB/EXEC/DECODE as specified. Exactly one pc_en pulse per instruction.

Optional Feature:
- Macro: SEQ_INSTR_CNT_EN.
- Defined:
  - Adds output instr_count [CNT_W-1:0].
  - Increments on every pc_en pulse and wraps from all-ones to 0.
  - Reset to 0 by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- R-type: rst, run=1, mem_ready=1 every cycle, opcode=0, aluop=3 -> state sequence FETCH, DECODE, EXEC, WB, FETCH. alu_signal=3 in EXEC; reg_write=1 and pc_en=1 in WB; 4 cycles per instruction.
- Load with 3-cycle memory wait: opcode=2, mem_ready low 3 cycles in MEM -> mem_req=1, mem_sel=1, mem_we=0 for 4 cycles. WB has data_from_mem=1.
- Branch: opcode=4, zero_flag=1 -> pc_en=1 and branch=1 in EXEC. With zero_flag=0: pc_en=1, branch=0.
- Timeout: MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> FAULT after 15 cycles, mem_req drops, fault=1. fault is 0 the cycle after rst.
- Illegal/halt: opcode=7 -> fault=1, pc_en pulse, next FETCH. Then opcode=31 -> halted=1, busy=0. rst asserted mid-MEM of a store -> mem_we=0 next cycle, state IDLE.
- SEQ_INSTR_CNT_EN with CNT_W=4: execute 17 instructions -> instr_count=1 (wrapped).
